// File: rtl/mem_request_queue.sv
// mem_request_queue: in-order load/store queue feeding memory_unit.
// Buffers up to DEPTH requests, issues one per launch on mem_isld/mem_isst,
// captures mem_ldresult LD_LATENCY cycles after a load launch and returns it
// with its tag on the wb_* port. Malformed requests (isld==isst) are dropped.
// Optional feature: define STORE_FWD_EN to forward queued store data to a
// younger load at the same address through a one-entry forward buffer.
module mem_request_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 4,
  parameter int LD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_isld,
  input  logic                     in_isst,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     mem_isld,
  output logic                     mem_isst,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_ldresult,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [DATA_W-1:0]        wb_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int LCW = (LD_LATENCY > 1) ? $clog2(LD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nx;

  logic              q_isld [DEPTH];
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [TAG_W-1:0]  q_tag  [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LCW-1:0]   lat_cnt;
  logic [TAG_W-1:0] iss_tag;
  logic             enq, pop, ld_done;

`ifdef STORE_FWD_EN
  logic              fwd_full, fwd_match, fwd_hit;
  logic [TAG_W-1:0]  fwd_tag;
  logic [DATA_W-1:0] fwd_data, fwd_sel;
  logic [PW-1:0]     fwd_idx;

  // Find the youngest unissued store whose address matches the incoming load.
  always_comb begin
    fwd_match = 1'b0;
    fwd_sel   = '0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && !q_isld[fwd_idx] && (q_addr[fwd_idx] == in_addr)) begin
        fwd_match = 1'b1;
        fwd_sel   = q_data[fwd_idx];
      end
    end
  end

  // Accept/enqueue decisions; forwarded loads bypass the queue entirely.
  always_comb begin
    in_ready = (count < CW'(DEPTH)) && !fwd_full;
    fwd_hit  = in_valid && in_ready && in_isld && !in_isst && fwd_match;
    enq      = in_valid && in_ready && (in_isld ^ in_isst) && !fwd_hit;
  end
`else
  // Accept/enqueue decisions; malformed requests are accepted but dropped.
  always_comb begin
    in_ready = (count < CW'(DEPTH));
    enq      = in_valid && in_ready && (in_isld ^ in_isst);
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: launch from IDLE, hold off further issue while a load is outstanding.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (count != '0) state_nx = ISSUE;
      ISSUE:   state_nx = mem_isld ? WAIT : IDLE;
      WAIT:    if (lat_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: queue pop on launch, load-result capture strobe.
  always_comb begin
    pop     = (state == IDLE) && (count != '0);
    ld_done = (state == WAIT) && (lat_cnt == '0);
  end

  // Queue storage, pointers, registered memory interface and writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_isld  <= 1'b0;
      mem_isst  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      iss_tag   <= '0;
      lat_cnt   <= '0;
      wb_valid  <= 1'b0;
      wb_tag    <= '0;
      wb_data   <= '0;
`ifdef STORE_FWD_EN
      fwd_full  <= 1'b0;
      fwd_tag   <= '0;
      fwd_data  <= '0;
`endif
    end else begin
      if (enq) begin
        q_isld[wr_ptr] <= in_isld;
        q_addr[wr_ptr] <= in_addr;
        q_data[wr_ptr] <= in_data;
        q_tag[wr_ptr]  <= in_tag;
        wr_ptr         <= wr_ptr + PW'(1);
      end

      if (pop) begin
        mem_isld  <= q_isld[rd_ptr];
        mem_isst  <= !q_isld[rd_ptr];
        mem_addr  <= q_addr[rd_ptr];
        mem_wdata <= q_data[rd_ptr];
        iss_tag   <= q_tag[rd_ptr];
        rd_ptr    <= rd_ptr + PW'(1);
      end else begin
        mem_isld <= 1'b0;
        mem_isst <= 1'b0;
      end

      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (state == ISSUE)
        lat_cnt <= LCW'(LD_LATENCY - 1);
      else if ((state == WAIT) && (lat_cnt != '0))
        lat_cnt <= lat_cnt - LCW'(1);

      wb_valid <= 1'b0;
      if (ld_done) begin
        wb_valid <= 1'b1;
        wb_tag   <= iss_tag;
        wb_data  <= mem_ldresult;
      end
`ifdef STORE_FWD_EN
      // Memory return owns the wb port on a tie; the forward buffer waits a cycle.
      else if (fwd_full) begin
        wb_valid <= 1'b1;
        wb_tag   <= fwd_tag;
        wb_data  <= fwd_data;
        fwd_full <= 1'b0;
      end
      if (fwd_hit) begin
        fwd_full <= 1'b1;
        fwd_tag  <= in_tag;
        fwd_data <= fwd_sel;
      end
`endif
    end
  end

endmodule
